uart_tx_param: RTL and testbench

UART_TX_PARAM -- requirements
Module: uart_tx_param

---
 rtl/uart_tx_param.sv | 128 ++++++++++++
 tb/tb_uart_tx_param.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
// uart_tx_param: FIFO-buffered UART transmitter with per-frame latched divisor, parity and stop-bit options.
module uart_tx_param #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic [DATA_W-1:0]             data_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    input  logic [DIV_W-1:0]              div_i,
    input  logic                          parity_en_i,
    input  logic                          parity_odd_i,
    input  logic                          stop2_i,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);
    localparam logic [BW-1:0] LAST = BW'(DATA_W);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

    state_t              state, state_d;
    logic [DATA_W-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [LW-1:0]       level;
    logic [DIV_W-1:0]    cnt, cnt_d, div_q;
    logic [BW-1:0]       bit_cnt, bit_d;
    logic [DATA_W-1:0]   sh, sh_d;
    logic                par_q, par_en_q, stop2_q, tx_q, tx_d, push, pop, empty;

    assign ready_o      = level != FULL;
    assign empty        = level == '0;
    assign push         = valid_i && ready_o;
    assign tx_o         = tx_q;
    assign busy_o       = state != IDLE;
    assign fifo_level_o = level;

    always_ff @(posedge clk_i)
        if (push) mem[wr_ptr] <= data_i;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            sh       <= '0;
            tx_q     <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            div_q    <= '0;
            par_en_q <= 1'b0;
            stop2_q  <= 1'b0;
            par_q    <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            bit_cnt <= bit_d;
            sh      <= sh_d;
            tx_q    <= tx_d;
            wr_ptr  <= wr_ptr + AW'(push);
            rd_ptr  <= rd_ptr + AW'(pop);
            level   <= level + LW'(push) - LW'(pop);
            if (pop) begin
                div_q    <= div_i;
                par_en_q <= parity_en_i;
                stop2_q  <= stop2_i;
                par_q    <= ^mem[rd_ptr] ^ parity_odd_i;
            end
        end
    end

    // Any path that lands in IDLE (staying idle or finishing a frame) launches the next queued word instead.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        bit_d   = bit_cnt;
        sh_d    = sh;
        tx_d    = tx_q;
        pop     = 1'b0;
        if (state != IDLE) cnt_d = cnt - DIV_W'(1);
        if (state != IDLE && cnt == '0) begin
            cnt_d = div_q;
            case (state)
                START: begin
                    state_d = DATA;
                    tx_d    = sh[0];
                    sh_d    = sh >> 1;
                    bit_d   = BW'(1);
                end
                DATA: begin
                    if (bit_cnt != LAST) begin
                        tx_d  = sh[0];
                        sh_d  = sh >> 1;
                        bit_d = bit_cnt + BW'(1);
                    end else begin
                        state_d = par_en_q ? PARITY : STOP1;
                        tx_d    = par_en_q ? par_q : 1'b1;
                    end
                end
                PARITY: begin
                    state_d = STOP1;
                    tx_d    = 1'b1;
                end
                STOP1:   state_d = stop2_q ? STOP2 : IDLE;
                default: state_d = IDLE;
            endcase
        end
        if (state_d == IDLE) begin
            cnt_d = '0;
            bit_d = '0;
            tx_d  = 1'b1;
            if (!empty) begin
                pop     = 1'b1;
                state_d = START;
                tx_d    = 1'b0;
                cnt_d   = div_i;
                sh_d    = mem[rd_ptr];
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: directed checks of framing, parity, FIFO flow control, config latching and reset abort.
module tb_uart_tx_param;
    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b1;
    logic [7:0]  data_i;
    logic        valid_i;
    logic        ready_o;
    logic [15:0] div_i;
    logic        parity_en_i, parity_odd_i, stop2_i;
    logic        tx_o, busy_o;
    logic [3:0]  fifo_level_o;
    int          vectors = 0;
    int          miscompares = 0;
    int          acc;
    logic [7:0]  w;

    always #5 clk_i = ~clk_i;

    uart_tx_param dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
        .div_i(div_i), .parity_en_i(parity_en_i), .parity_odd_i(parity_odd_i), .stop2_i(stop2_i),
        .tx_o(tx_o), .busy_o(busy_o), .fifo_level_o(fifo_level_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] v);
        data_i  = v;
        valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
    endtask

    // bits[0] is the first bit on the line; each bit must hold for div+1 cycles with busy_o high.
    task automatic expect_frame(input string tag, input logic [11:0] bits, input int n, input int div,
                                input bit wait_start);
        if (wait_start)
            for (int t = 0; t < 100; t++) begin
                @(negedge clk_i);
                if (tx_o === 1'b0) break;
            end
        for (int i = 0; i < n; i++)
            for (int d = 0; d <= div; d++) begin
                check(tag, tx_o, bits[i]);
                check({tag, "_busy"}, busy_o, 1'b1);
                @(negedge clk_i);
            end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        valid_i = 0; data_i = 0; div_i = 3;
        parity_en_i = 0; parity_odd_i = 0; stop2_i = 0;
        #3 rstn_i = 1'b0;
        #1;
        check("rst_tx", tx_o, 1'b1);
        check("rst_busy", busy_o, 1'b0);
        check("rst_ready", ready_o, 1'b1);
        check("rst_level", fifo_level_o, 4'd0);
        repeat (2) @(negedge clk_i);
        rstn_i = 1'b1;
        repeat (5) @(negedge clk_i);
        check("idle_busy", busy_o, 1'b0);
        check("idle_tx", tx_o, 1'b1);
        check("idle_level", fifo_level_o, 4'd0);

        push(8'hA5);
        @(negedge clk_i);
        check("nobypass_tx", tx_o, 1'b1);
        check("nobypass_busy", busy_o, 1'b0);
        check("nobypass_level", fifo_level_o, 4'd1);
        @(negedge clk_i);
        expect_frame("a5_plain", 12'b1_10100101_0, 10, 3, 1'b0);
        check("a5_plain_end_busy", busy_o, 1'b0);
        check("a5_plain_end_tx", tx_o, 1'b1);

        parity_en_i = 1;
        push(8'hA5);
        expect_frame("a5_even", 12'b1_0_10100101_0, 11, 3, 1'b1);
        check("a5_even_end_busy", busy_o, 1'b0);
        parity_odd_i = 1;
        push(8'hA5);
        expect_frame("a5_odd", 12'b1_1_10100101_0, 11, 3, 1'b1);
        check("a5_odd_end_busy", busy_o, 1'b0);

        parity_en_i = 0; parity_odd_i = 0; stop2_i = 1; div_i = 0;
        push(8'h3C);
        push(8'h81);
        expect_frame("b2b_first", 12'b11_00111100_0, 11, 0, 1'b1);
        expect_frame("b2b_second", 12'b11_10000001_0, 11, 0, 1'b0);
        check("b2b_end_busy", busy_o, 1'b0);

        stop2_i = 0; div_i = 3;
        push(8'h5A);
        push(8'hC3);
        div_i = 7;
        expect_frame("div_old", 12'b1_01011010_0, 10, 3, 1'b1);
        expect_frame("div_new", 12'b1_11000011_0, 10, 7, 1'b0);
        check("div_end_busy", busy_o, 1'b0);

        div_i = 15;
        acc = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk_i);
            if (!ready_o) break;
            data_i  = 8'h10 + acc[7:0];
            valid_i = 1'b1;
            acc++;
        end
        check("fill_accepted", acc, 9);
        check("fill_level", fifo_level_o, 4'd8);
        data_i = 8'hEE;
        div_i  = 0;
        repeat (3) @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        check("full_level", fifo_level_o, 4'd8);
        check("full_ready", ready_o, 1'b0);
        for (int t = 0; t < 300; t++) begin
            @(negedge clk_i);
            if (ready_o) break;
        end
        check("refill_ready", ready_o, 1'b1);
        check("refill_level", fifo_level_o, 4'd7);
        check("refill_tx", tx_o, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            w = 8'h10 + 8'(i);
            expect_frame("fifo_order", {2'b00, 1'b1, w, 1'b0}, 10, 0, 1'b0);
        end
        check("drain_busy", busy_o, 1'b0);
        check("drain_level", fifo_level_o, 4'd0);

        div_i = 3;
        push(8'h00);
        push(8'h01);
        push(8'h02);
        push(8'h03);
        repeat (4) @(negedge clk_i);
        check("pre_rst_tx", tx_o, 1'b0);
        check("pre_rst_busy", busy_o, 1'b1);
        check("pre_rst_level", fifo_level_o, 4'd3);
        #2 rstn_i = 1'b0;
        #1;
        check("abort_tx", tx_o, 1'b1);
        check("abort_busy", busy_o, 1'b0);
        check("abort_level", fifo_level_o, 4'd0);
        check("abort_ready", ready_o, 1'b1);
        @(posedge clk_i);
        @(negedge clk_i);
        rstn_i = 1'b1;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk_i);
            check("post_rst_tx", tx_o, 1'b1);
            check("post_rst_busy", busy_o, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
